// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor (BHT + BTB).
//
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   req_*                 decode-stage prediction request (valid, pc, direct target, static hint)
//   pred_*                combinational prediction (hit, taken, target)
//   fb_*                  execute-stage resolved branch/jump feedback
//   redirect, redirect_pc combinational fetch restart on mispredict
//   mispredict_count      saturating count of mispredict cycles
//
// Each entry holds a valid bit, tag, 2-bit saturating counter and target. The table is
// trained one cycle after feedback; a request in the same cycle sees the old contents.

`ifndef PC_SIZE
`define PC_SIZE 8
`endif

module branch_predictor #(
  parameter int unsigned PC_W  = `PC_SIZE,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             req_valid,
  input  logic [PC_W-1:0]  req_pc,
  input  logic [PC_W-1:0]  req_target,
  input  logic             req_ps,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             fb_branch,
  input  logic             fb_jump,
  input  logic [PC_W-1:0]  fb_pc,
  input  logic [PC_W-1:0]  fb_predict_target,
  input  logic [PC_W-1:0]  fb_feedback_target,
  input  logic             fb_predict_taken,
  input  logic             fb_feedback_taken,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int unsigned Entries = 1 << IDX_W;
  localparam int unsigned TagW    = PC_W - IDX_W;

  logic            valid_q [Entries];
  logic            valid_d [Entries];
  logic [TagW-1:0] tag_q   [Entries];
  logic [TagW-1:0] tag_d   [Entries];
  logic [1:0]      cnt_q   [Entries];
  logic [1:0]      cnt_d   [Entries];
  logic [PC_W-1:0] tgt_q   [Entries];
  logic [PC_W-1:0] tgt_d   [Entries];

  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

  logic [IDX_W-1:0] req_idx, fb_idx;
  logic [TagW-1:0]  req_tag, fb_tag;
  logic             fb_valid, fb_hit, mispredict;
  logic [PC_W-1:0]  fb_pc_inc;

  assign req_idx   = req_pc[IDX_W-1:0];
  assign req_tag   = req_pc[PC_W-1:IDX_W];
  assign fb_idx    = fb_pc[IDX_W-1:0];
  assign fb_tag    = fb_pc[PC_W-1:IDX_W];
  assign fb_valid  = fb_branch | fb_jump;
  assign fb_hit    = valid_q[fb_idx] && (tag_q[fb_idx] == fb_tag);
  // Fall-through address; wraps naturally at all-ones.
  assign fb_pc_inc = fb_pc + {{(PC_W-1){1'b0}}, 1'b1};

  // Prediction reads registered state only, so same-cycle training is not bypassed.
  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = '0;
    if (req_valid) begin
      if (valid_q[req_idx] && (tag_q[req_idx] == req_tag)) begin
        pred_hit    = 1'b1;
        pred_taken  = cnt_q[req_idx][1];
        pred_target = tgt_q[req_idx];
      end else begin
        pred_taken  = req_ps;
        pred_target = req_target;
      end
    end
  end

  always_comb begin
    mispredict = fb_valid &&
                 ((fb_predict_taken != fb_feedback_taken) ||
                  (fb_feedback_taken && (fb_predict_target != fb_feedback_target)));
    redirect    = mispredict;
    redirect_pc = '0;
    if (mispredict) begin
      redirect_pc = fb_feedback_taken ? fb_feedback_target : fb_pc_inc;
    end
  end

  // Table training; a jump wins over a branch when both flags are set.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    if (fb_valid) begin
      if (fb_hit) begin
        if (fb_jump) begin
          cnt_d[fb_idx] = 2'd3;
          tgt_d[fb_idx] = fb_feedback_target;
        end else if (fb_feedback_taken) begin
          if (cnt_q[fb_idx] != 2'd3) cnt_d[fb_idx] = cnt_q[fb_idx] + 2'd1;
          tgt_d[fb_idx] = fb_feedback_target;
        end else begin
          if (cnt_q[fb_idx] != 2'd0) cnt_d[fb_idx] = cnt_q[fb_idx] - 2'd1;
        end
      end else begin
        valid_d[fb_idx] = 1'b1;
        tag_d[fb_idx]   = fb_tag;
        if (fb_jump) begin
          cnt_d[fb_idx] = 2'd3;
          tgt_d[fb_idx] = fb_feedback_target;
        end else begin
          cnt_d[fb_idx] = fb_feedback_taken ? 2'd2 : 2'd1;
          tgt_d[fb_idx] = fb_feedback_taken ? fb_feedback_target : fb_pc_inc;
        end
      end
    end
  end

  always_comb begin
    mispredict_count_d = mispredict_count_q;
    if (mispredict && (mispredict_count_q != {CNT_W{1'b1}})) begin
      mispredict_count_d = mispredict_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign mispredict_count = mispredict_count_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(Entries); i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        cnt_q[i]   <= 2'b01;
        tgt_q[i]   <= '0;
      end
      mispredict_count_q <= '0;
    end else begin
      valid_q            <= valid_d;
      tag_q              <= tag_d;
      cnt_q              <= cnt_d;
      tgt_q              <= tgt_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus pushes expected responses stamped with
// the cycle they apply to; a monitor pops and compares them on the falling edge.
module tb_branch_predictor;

  localparam int unsigned PcW  = 8;
  localparam int unsigned CntW = 4;

  logic            clk = 1'b0;
  logic            n_rst;
  logic            req_valid, req_ps;
  logic [PcW-1:0]  req_pc, req_target;
  logic            pred_hit, pred_taken;
  logic [PcW-1:0]  pred_target;
  logic            fb_branch, fb_jump, fb_predict_taken, fb_feedback_taken;
  logic [PcW-1:0]  fb_pc, fb_predict_target, fb_feedback_target;
  logic            redirect;
  logic [PcW-1:0]  redirect_pc;
  logic [CntW-1:0] mispredict_count;

  branch_predictor #(.PC_W(PcW), .IDX_W(4), .CNT_W(CntW)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .req_valid          (req_valid),
    .req_pc             (req_pc),
    .req_target         (req_target),
    .req_ps             (req_ps),
    .pred_hit           (pred_hit),
    .pred_taken         (pred_taken),
    .pred_target        (pred_target),
    .fb_branch          (fb_branch),
    .fb_jump            (fb_jump),
    .fb_pc              (fb_pc),
    .fb_predict_target  (fb_predict_target),
    .fb_feedback_target (fb_feedback_target),
    .fb_predict_taken   (fb_predict_taken),
    .fb_feedback_taken  (fb_feedback_taken),
    .redirect           (redirect),
    .redirect_pc        (redirect_pc),
    .mispredict_count   (mispredict_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind 0: prediction (a=hit, b=taken, c=target); 1: redirect (a, c=pc); 2: count (c)
  typedef struct {
    int         cyc;
    int         kind;
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d checked at cycle %0d", e.name, e.cyc, cyc);
      end else if (e.kind == 0) begin
        if (pred_hit !== e.a[0] || pred_taken !== e.b[0] || pred_target !== e.c) begin
          failures++;
          $display("FAIL %s: got hit=%0b taken=%0b target=%h, want hit=%0b taken=%0b target=%h",
                   e.name, pred_hit, pred_taken, pred_target, e.a[0], e.b[0], e.c);
        end
      end else if (e.kind == 1) begin
        if (redirect !== e.a[0] || redirect_pc !== e.c) begin
          failures++;
          $display("FAIL %s: got redirect=%0b pc=%h, want redirect=%0b pc=%h",
                   e.name, redirect, redirect_pc, e.a[0], e.c);
        end
      end else begin
        if (mispredict_count !== e.c[CntW-1:0]) begin
          failures++;
          $display("FAIL %s: got count=%0d, want count=%0d",
                   e.name, mispredict_count, e.c[CntW-1:0]);
        end
      end
    end
  end

  task automatic clear_inputs();
    req_valid = 1'b0; req_pc = '0; req_target = '0; req_ps = 1'b0;
    fb_branch = 1'b0; fb_jump = 1'b0; fb_pc = '0;
    fb_predict_target = '0; fb_feedback_target = '0;
    fb_predict_taken = 1'b0; fb_feedback_taken = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic req(input logic [7:0] pc, input logic [7:0] tg, input logic ps);
    req_valid = 1'b1; req_pc = pc; req_target = tg; req_ps = ps;
  endtask

  task automatic fb(input logic br, input logic jmp, input logic [7:0] pc,
                    input logic [7:0] ptgt, input logic [7:0] ftgt,
                    input logic ptk, input logic ftk);
    fb_branch = br; fb_jump = jmp; fb_pc = pc;
    fb_predict_target = ptgt; fb_feedback_target = ftgt;
    fb_predict_taken = ptk; fb_feedback_taken = ftk;
  endtask

  task automatic exp_pred(input string n, input logic h, input logic t, input logic [7:0] tg);
    sb.push_back('{cyc, 0, n, {7'd0, h}, {7'd0, t}, tg});
  endtask

  task automatic exp_redir(input string n, input logic r, input logic [7:0] pc);
    sb.push_back('{cyc, 1, n, {7'd0, r}, 8'd0, pc});
  endtask

  task automatic exp_cnt(input string n, input logic [7:0] c);
    sb.push_back('{cyc, 2, n, 8'd0, 8'd0, c});
  endtask

  initial begin
    n_rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;

    // Reset state: miss uses static hint and decode target.
    next(); req(8'h12, 8'h40, 1'b1);
    exp_pred("reset_pred", 1'b0, 1'b1, 8'h40); exp_cnt("reset_cnt", 8'd0);
    exp_redir("reset_redir", 1'b0, 8'h00);

    // Train 0x12 taken twice: alloc cnt=2, then cnt=3.
    next(); fb(1, 0, 8'h12, 8'h40, 8'h40, 1, 1); exp_redir("train1_redir", 1'b0, 8'h00);
    next(); fb(1, 0, 8'h12, 8'h40, 8'h40, 1, 1); exp_redir("train2_redir", 1'b0, 8'h00);
    next(); req(8'h12, 8'h00, 1'b0); exp_pred("trained_pred", 1'b1, 1'b1, 8'h40);

    // Not-taken #1 (mispredict): cnt 3->2.
    next(); fb(1, 0, 8'h12, 8'h40, 8'h40, 1, 0); exp_redir("nt1_redir", 1'b1, 8'h13);
    // Not-taken #2 with same-index request: request sees cnt=2, update takes it to 1.
    next(); fb(1, 0, 8'h12, 8'h40, 8'h40, 1, 0); req(8'h12, 8'h00, 1'b0);
    exp_pred("nobypass_old", 1'b1, 1'b1, 8'h40); exp_redir("nt2_redir", 1'b1, 8'h13);
    exp_cnt("cnt_after_nt1", 8'd1);
    // New prediction visible; not-taken #3 correctly predicted: cnt 1->0.
    next(); fb(1, 0, 8'h12, 8'h40, 8'h40, 0, 0); req(8'h12, 8'h00, 1'b1);
    exp_pred("nobypass_new", 1'b1, 1'b0, 8'h40); exp_redir("nt3_redir", 1'b0, 8'h00);
    exp_cnt("cnt_after_nt2", 8'd2);
    // Not-taken #4 must saturate at 0.
    next(); fb(1, 0, 8'h12, 8'h40, 8'h40, 0, 0);
    next(); req(8'h12, 8'h00, 1'b1); exp_pred("sat_zero", 1'b1, 1'b0, 8'h40);

    // Jump mispredict at 0x05.
    next(); fb(0, 1, 8'h05, 8'h00, 8'h30, 0, 1); exp_redir("jump_redir", 1'b1, 8'h30);
    next(); req(8'h05, 8'h99, 1'b0); exp_pred("jump_pred", 1'b1, 1'b1, 8'h30);
    exp_cnt("cnt_after_jump", 8'd3);

    // Alias: 0x02 replaces 0x12, then 0x12 replaces 0x02.
    next(); fb(1, 0, 8'h02, 8'h50, 8'h50, 1, 1); exp_redir("alias_train", 1'b0, 8'h00);
    next(); req(8'h02, 8'h11, 1'b0); fb(1, 0, 8'h12, 8'h00, 8'h77, 0, 0);
    exp_pred("alias_02_hit", 1'b1, 1'b1, 8'h50);
    next(); req(8'h02, 8'h11, 1'b0); exp_pred("alias_02_miss", 1'b0, 1'b0, 8'h11);
    next(); req(8'h12, 8'h11, 1'b1); exp_pred("alias_12_hit", 1'b1, 1'b0, 8'h13);

    // Wrap of fall-through address at all-ones.
    next(); fb(1, 0, 8'hff, 8'h20, 8'h20, 1, 0); exp_redir("wrap_redir", 1'b1, 8'h00);
    next(); req(8'hff, 8'h77, 1'b1); exp_pred("wrap_pred", 1'b1, 1'b0, 8'h00);
    exp_cnt("cnt_after_wrap", 8'd4);

    // Jump has priority over branch: allocate with cnt=3, one not-taken leaves it taken.
    next(); fb(1, 1, 8'h33, 8'h60, 8'h60, 1, 1); exp_redir("prio_redir", 1'b0, 8'h00);
    next(); fb(1, 0, 8'h33, 8'h60, 8'h60, 1, 0); exp_redir("prio_nt_redir", 1'b1, 8'h34);
    next(); req(8'h33, 8'h00, 1'b0); exp_pred("prio_pred", 1'b1, 1'b1, 8'h60);
    exp_cnt("cnt_after_prio", 8'd5);

    // req_valid low: outputs all zero even with a trained pc on the bus.
    next(); req_pc = 8'h05; req_target = 8'h44; req_ps = 1'b1;
    exp_pred("req_idle", 1'b0, 1'b0, 8'h00);

    // Drive count to all-ones (5 + 10 = 15), then one more mispredict.
    for (int i = 0; i < 10; i++) begin
      next(); fb(0, 1, 8'h40, 8'h00, 8'h41, 0, 1);
    end
    next(); fb(0, 1, 8'h40, 8'h00, 8'h41, 0, 1); exp_cnt("cnt_full", 8'd15);
    exp_redir("sat_redir", 1'b1, 8'h41);
    next(); exp_cnt("cnt_saturated", 8'd15);

    // Asynchronous reset mid-training, checked before the next clock edge.
    next(); fb(1, 0, 8'h05, 8'h30, 8'h30, 1, 1); req(8'h05, 8'h22, 1'b0);
    n_rst = 1'b0;
    exp_pred("async_rst_pred", 1'b0, 1'b0, 8'h22); exp_cnt("async_rst_cnt", 8'd0);
    next(); n_rst = 1'b1; req(8'h33, 8'h23, 1'b1);
    exp_pred("post_rst_pred", 1'b0, 1'b1, 8'h23); exp_cnt("post_rst_cnt", 8'd0);

    next(); next();
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
